// File: rtl/ieee754_accumulator_pkg.sv
// rtl/ieee754_accumulator_pkg.sv - shared float constants and accumulator FSM states
package ieee754_accumulator_pkg;

    localparam int FLT_W = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [FLT_W-1:0] FLT_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ADD    = 2'd1,
        ST_CONV   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/ieee754_adder.sv
// rtl/ieee754_adder.sv - combinational single-precision adder, RNE, flush-to-zero
//
// Ports:
//   i_a, i_b : float operands
//   o_y      : float sum
module ieee754_adder
    import ieee754_accumulator_pkg::*;
(
    input  logic [FLT_W-1:0] i_a,
    input  logic [FLT_W-1:0] i_b,
    output logic [FLT_W-1:0] o_y
);

    localparam int XW = MAN_W + 4;          // hidden bit + fraction + guard/round/sticky

    logic             w_a_s, w_b_s, w_big_s, w_sm_s;
    logic [EXP_W-1:0] w_a_e, w_b_e, w_big_e, w_sm_e, w_d;
    logic [MAN_W-1:0] w_a_m, w_b_m, w_big_m, w_sm_m;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [XW-1:0]    w_big_x, w_sm_x, w_sm_sh, w_diff, w_norm;
    logic [XW:0]      w_sum;
    logic [4:0]       w_lz;
    logic             w_found, w_lost, w_round_up;
    logic [9:0]       w_exp;
    logic [MAN_W+1:0] w_mant;
    logic [MAN_W-1:0] w_frac;

    always_comb begin
        w_a_s = i_a[FLT_W-1];
        w_a_e = i_a[FLT_W-2:MAN_W];
        w_a_m = i_a[MAN_W-1:0];
        w_b_s = i_b[FLT_W-1];
        w_b_e = i_b[FLT_W-2:MAN_W];
        w_b_m = i_b[MAN_W-1:0];

        w_a_nan  = (&w_a_e) && (|w_a_m);
        w_b_nan  = (&w_b_e) && (|w_b_m);
        w_a_inf  = (&w_a_e) && !(|w_a_m);
        w_b_inf  = (&w_b_e) && !(|w_b_m);
        // Zero and subnormal operands are both treated as zero.
        w_a_zero = !(|w_a_e);
        w_b_zero = !(|w_b_e);

        // Order operands by magnitude so the subtraction never goes negative.
        if (i_a[FLT_W-2:0] >= i_b[FLT_W-2:0]) begin
            w_big_s = w_a_s; w_big_e = w_a_e; w_big_m = w_a_m;
            w_sm_s  = w_b_s; w_sm_e  = w_b_e; w_sm_m  = w_b_m;
        end else begin
            w_big_s = w_b_s; w_big_e = w_b_e; w_big_m = w_b_m;
            w_sm_s  = w_a_s; w_sm_e  = w_a_e; w_sm_m  = w_a_m;
        end

        w_d     = w_big_e - w_sm_e;
        w_big_x = {1'b1, w_big_m, 3'b000};
        w_sm_x  = {1'b1, w_sm_m, 3'b000};

        // Alignment shift; every bit shifted out is folded into the sticky bit.
        if (w_d >= 8'(XW)) begin
            w_sm_sh = XW'(1);
            w_lost  = 1'b1;
        end else begin
            w_lost  = |(w_sm_x & ((XW'(1) << w_d) - XW'(1)));
            w_sm_sh = (w_sm_x >> w_d) | XW'(w_lost);
        end

        w_sum   = '0;
        w_diff  = '0;
        w_lz    = '0;
        w_found = 1'b0;
        if (w_big_s == w_sm_s) begin
            w_sum = {1'b0, w_big_x} + {1'b0, w_sm_sh};
            if (w_sum[XW]) begin
                w_norm = {w_sum[XW:2], w_sum[1] | w_sum[0]};
                w_exp  = {2'b00, w_big_e} + 10'd1;
            end else begin
                w_norm = w_sum[XW-1:0];
                w_exp  = {2'b00, w_big_e};
            end
        end else begin
            w_diff = w_big_x - w_sm_sh;
            for (int i = XW - 1; i >= 0; i--) begin
                if (!w_found && w_diff[i]) begin
                    w_lz    = 5'(XW - 1 - i);
                    w_found = 1'b1;
                end
            end
            w_norm = w_diff << w_lz;
            w_exp  = {2'b00, w_big_e} - {5'd0, w_lz};
        end

        // Round to nearest, ties to even on the 24-bit significand.
        w_round_up = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
        w_mant     = {1'b0, w_norm[XW-1:3]} + (MAN_W + 2)'(w_round_up);
        if (w_mant[MAN_W+1]) begin
            w_exp  = w_exp + 10'd1;
            w_frac = w_mant[MAN_W:1];
        end else begin
            w_frac = w_mant[MAN_W-1:0];
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s != w_b_s))) begin
            o_y = FLT_NAN;
        end else if (w_a_inf) begin
            o_y = i_a;
        end else if (w_b_inf) begin
            o_y = i_b;
        end else if (w_a_zero && w_b_zero) begin
            o_y = '0;
        end else if (w_a_zero) begin
            o_y = i_b;
        end else if (w_b_zero) begin
            o_y = i_a;
        end else if ((w_big_s != w_sm_s) && !w_found) begin
            o_y = '0;                       // exact cancellation is +0
        end else if (w_exp[9] || (w_exp == 10'd0)) begin
            o_y = '0;                       // underflow flushes to +0
        end else if (w_exp >= 10'd255) begin
            o_y = {w_big_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            o_y = {w_big_s, w_exp[EXP_W-1:0], w_frac};
        end
    end

endmodule

// File: rtl/ieee754_accumulator.sv
// rtl/ieee754_accumulator.sv - float batch accumulator producing sum and count for a divider
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready       : element handshake, in_data element, in_last closes batch
//   out_valid/out_ready     : batch handshake towards the divider
//   out_sum, out_count      : batch sum and element count, both as floats
//   out_overflow            : count saturated during the batch
module ieee754_accumulator
    import ieee754_accumulator_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLT_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLT_W-1:0] out_sum,
    output logic [FLT_W-1:0] out_count,
    output logic             out_overflow
);

    state_t             r_state;
    logic [FLT_W-1:0]   r_operand;
    logic               r_last;
    logic [FLT_W-1:0]   r_sum;
    logic [COUNT_W-1:0] r_count;
    logic               r_overflow;
    logic [FLT_W-1:0]   r_count_flt;

    logic [FLT_W-1:0]   w_add_y;
    logic [23:0]        w_cnt24;
    logic [23:0]        w_cnt_sh;
    logic [4:0]         w_msb;
    logic [FLT_W-1:0]   w_cnt_flt;

    ieee754_adder u_adder (
        .i_a (r_sum),
        .i_b (r_operand),
        .o_y (w_add_y)
    );

    // Count to float: the count fits in 24 bits, so the conversion is exact.
    always_comb begin
        w_cnt24 = 24'(r_count);
        w_msb   = '0;
        for (int i = 0; i < 24; i++) begin
            if (w_cnt24[i]) begin
                w_msb = 5'(i);
            end
        end
        w_cnt_sh = w_cnt24 << (5'd23 - w_msb);
        if (w_cnt24 == '0) begin
            w_cnt_flt = '0;
        end else begin
            w_cnt_flt = {1'b0, 8'(BIAS) + {3'b000, w_msb}, w_cnt_sh[MAN_W-1:0]};
        end
    end

    // reset_n gates in_ready so upstream sees no acceptance while held in reset.
    assign in_ready     = (r_state == ST_ACCEPT) && reset_n;
    assign out_valid    = (r_state == ST_EMIT);
    assign out_sum      = r_sum;
    assign out_count    = r_count_flt;
    assign out_overflow = r_overflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ACCEPT;
            r_operand   <= '0;
            r_last      <= 1'b0;
            r_sum       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_count_flt <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (in_valid) begin
                        r_operand <= in_data;
                        r_last    <= in_last;
                        r_state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    // The adder propagates NaN, so a NaN sum stays NaN.
                    r_sum <= w_add_y;
                    if (&r_count) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                    r_state <= r_last ? ST_CONV : ST_ACCEPT;
                end
                ST_CONV: begin
                    r_count_flt <= w_cnt_flt;
                    r_state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        r_sum       <= '0;
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_count_flt <= '0;
                        r_state     <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee754_accumulator.sv
// tb/tb_ieee754_accumulator.sv - directed self-checking bench for ieee754_accumulator
module tb_ieee754_accumulator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        in_valid_drv;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready_drv;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [31:0] a_out_sum, a_out_count;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [31:0] b_out_sum, b_out_count;

    logic        m_in_ready, m_out_valid, m_out_overflow;
    logic [31:0] m_out_sum, m_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ieee754_accumulator #(.COUNT_W(16)) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid_drv & ~sel),
        .in_ready     (a_in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (a_out_valid),
        .out_ready    (out_ready_drv & ~sel),
        .out_sum      (a_out_sum),
        .out_count    (a_out_count),
        .out_overflow (a_out_overflow)
    );

    ieee754_accumulator #(.COUNT_W(2)) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid_drv & sel),
        .in_ready     (b_in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready_drv & sel),
        .out_sum      (b_out_sum),
        .out_count    (b_out_count),
        .out_overflow (b_out_overflow)
    );

    assign m_in_ready     = sel ? b_in_ready     : a_in_ready;
    assign m_out_valid    = sel ? b_out_valid    : a_out_valid;
    assign m_out_overflow = sel ? b_out_overflow : a_out_overflow;
    assign m_out_sum      = sel ? b_out_sum      : a_out_sum;
    assign m_out_count    = sel ? b_out_count    : a_out_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one element at a negedge and returns at the negedge after the handshake.
    task automatic push(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        while (!m_in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("push_ready_timeout", 32'(m_in_ready), 32'd1);
        in_valid_drv = 1'b1;
        in_data      = d;
        in_last      = last;
        @(negedge clock);
        in_valid_drv = 1'b0;
        in_last      = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(m_out_valid), 32'd1);
    endtask

    task automatic take_batch(input string tag, input logic [31:0] s, input logic [31:0] c,
                              input logic ovf);
        wait_valid({tag, "_valid"});
        check({tag, "_sum"}, m_out_sum, s);
        check({tag, "_count"}, m_out_count, c);
        check({tag, "_ovf"}, 32'(m_out_overflow), 32'(ovf));
        out_ready_drv = 1'b1;
        @(negedge clock);
        out_ready_drv = 1'b0;
        check({tag, "_valid_drop"}, 32'(m_out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(m_in_ready), 32'd1);
    endtask

    initial begin
        reset_n       = 1'b0;
        sel           = 1'b0;
        in_valid_drv  = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        out_ready_drv = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(m_in_ready), 32'd0);
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_sum", m_out_sum, 32'h0);
        check("rst_count", m_out_count, 32'h0);
        check("rst_ovf", 32'(m_out_overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_in_ready", 32'(m_in_ready), 32'd1);

        // 1 + 2 + 3
        push(32'h3F80_0000, 1'b0);
        push(32'h4000_0000, 1'b0);
        push(32'h4040_0000, 1'b1);
        take_batch("sum123", 32'h40C0_0000, 32'h4040_0000, 1'b0);

        // Single element with latency: ADD, CONV, then EMIT in the third cycle
        push(32'h4100_0000, 1'b1);
        check("lat_cyc1", 32'(m_out_valid), 32'd0);
        @(negedge clock);
        check("lat_cyc2", 32'(m_out_valid), 32'd0);
        @(negedge clock);
        check("lat_cyc3", 32'(m_out_valid), 32'd1);
        take_batch("single8", 32'h4100_0000, 32'h3F80_0000, 1'b0);

        // Exact cancellation
        push(32'h3F80_0000, 1'b0);
        push(32'hBF80_0000, 1'b1);
        take_batch("cancel", 32'h0000_0000, 32'h4000_0000, 1'b0);

        // NaN is sticky for the rest of the batch
        push(32'h3F80_0000, 1'b0);
        push(32'h7FC0_0001, 1'b0);
        push(32'h4000_0000, 1'b1);
        take_batch("nan", 32'h7FC0_0000, 32'h4040_0000, 1'b0);

        // Rounding: 1 + 2^-24 is a tie to even, 1 + (2^-24 + ulp) rounds up
        push(32'h3F80_0000, 1'b0);
        push(32'h3380_0000, 1'b1);
        take_batch("rne_tie", 32'h3F80_0000, 32'h4000_0000, 1'b0);
        push(32'h3F80_0000, 1'b0);
        push(32'h3380_0001, 1'b1);
        take_batch("rne_up", 32'h3F80_0001, 32'h4000_0000, 1'b0);

        // Mixed signs with renormalisation: 2 + (-1)
        push(32'h4000_0000, 1'b0);
        push(32'hBF80_0000, 1'b1);
        take_batch("sub_norm", 32'h3F80_0000, 32'h4000_0000, 1'b0);

        // Inf handling and exponent overflow
        push(32'h7F80_0000, 1'b0);
        push(32'h3F80_0000, 1'b1);
        take_batch("inf_fin", 32'h7F80_0000, 32'h4000_0000, 1'b0);
        push(32'h7F80_0000, 1'b0);
        push(32'hFF80_0000, 1'b1);
        take_batch("inf_minf", 32'h7FC0_0000, 32'h4000_0000, 1'b0);
        push(32'h7F7F_FFFF, 1'b0);
        push(32'h7F7F_FFFF, 1'b1);
        take_batch("exp_ovf", 32'h7F80_0000, 32'h4000_0000, 1'b0);

        // Subnormal flushes to +0
        push(32'h0000_0001, 1'b1);
        take_batch("subnorm", 32'h0000_0000, 32'h3F80_0000, 1'b0);

        // Downstream stall in EMIT: outputs stable, no acceptance
        push(32'h4000_0000, 1'b0);
        push(32'h4040_0000, 1'b1);
        wait_valid("hold_valid");
        in_valid_drv = 1'b1;
        in_data      = 32'h4480_0000;
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(m_out_valid), 32'd1);
            check("hold_sum", m_out_sum, 32'h40A0_0000);
            check("hold_count", m_out_count, 32'h4000_0000);
            check("hold_in_ready", 32'(m_in_ready), 32'd0);
            @(negedge clock);
        end
        in_valid_drv = 1'b0;
        take_batch("hold", 32'h40A0_0000, 32'h4000_0000, 1'b0);
        push(32'h3F80_0000, 1'b1);
        take_batch("after_hold", 32'h3F80_0000, 32'h3F80_0000, 1'b0);

        // Reset in the middle of a batch
        push(32'h3F80_0000, 1'b0);
        push(32'h4000_0000, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(m_in_ready), 32'd0);
        check("midrst_out_valid", 32'(m_out_valid), 32'd0);
        check("midrst_sum", m_out_sum, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        push(32'h4000_0000, 1'b1);
        take_batch("after_midrst", 32'h4000_0000, 32'h3F80_0000, 1'b0);

        // Reset while a batch waits in EMIT
        push(32'h4100_0000, 1'b1);
        wait_valid("emitrst_valid");
        reset_n = 1'b0;
        #1;
        check("emitrst_out_valid", 32'(m_out_valid), 32'd0);
        check("emitrst_sum", m_out_sum, 32'h0);
        check("emitrst_count", m_out_count, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        push(32'h4000_0000, 1'b1);
        take_batch("after_emitrst", 32'h4000_0000, 32'h3F80_0000, 1'b0);

        // COUNT_W=2: five ones saturate the count at 3
        sel = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            push(32'h3F80_0000, (i == 4));
        end
        take_batch("sat", 32'h40A0_0000, 32'h4040_0000, 1'b1);
        push(32'h3F80_0000, 1'b1);
        take_batch("after_sat", 32'h3F80_0000, 32'h3F80_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ieee754_accumulator.md
IEEE754_ACCUMULATOR -- requirements
Module: ieee754_accumulator

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, the element-counter width (legal range 1..24, so the count converts to float exactly).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_data and in_last are valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts the element this cycle.
REQ-006 SHALL have port in_data  input  32  the IEEE754 single-precision element.
REQ-007 SHALL have port in_last  input  1  this element closes the current batch.
REQ-008 SHALL have port out_valid  output  1  out_sum and out_count hold a finished batch.
REQ-009 SHALL have port out_ready  input  1  the downstream ieee754_divider stage takes the batch.
REQ-010 SHALL have port out_sum  output  32  the batch sum as a float; this is the divider dividend A.
REQ-011 SHALL have port out_count  output  32  the element count as a float; this is the divider divisor B.
REQ-012 SHALL have port out_overflow  output  1  the count saturated during this batch.

Function
REQ-013 SHALL implement an FSM with states ACCEPT, ADD, CONV and EMIT.
- After reset the FSM is in ACCEPT.
- The sum register is 0x00000000 and the count register is 0.
REQ-014 SHALL drive in_ready high only in ACCEPT.
- A handshake (in_valid && in_ready) latches in_data and in_last.
- On a handshake the FSM moves to ADD; without one it stays in ACCEPT.
REQ-015 SHALL, in ADD, compute sum <= sum + operand in one cycle and increment count.
- The count saturates at 2^COUNT_W-1; a saturated increment sets the overflow flag.
- Next state is CONV if the latched in_last is set, otherwise ACCEPT.
- Maximum input throughput is one element every 2 cycles.
REQ-016 SHALL, in CONV, convert count to an exact float in one cycle, then move to EMIT.
REQ-017 SHALL hold out_valid high in EMIT, with out_sum, out_count and out_overflow stable until out_ready is sampled high.
- On that cycle the FSM moves to ACCEPT.
- Sum, count and overflow are cleared on the same edge.
REQ-018 SHALL drive out_valid low in every state except EMIT.
REQ-019 SHALL give a latency of exactly 3 cycles from the in_last handshake edge to out_valid high.
REQ-020 SHALL follow these adder arithmetic rules:
- Exponent alignment uses guard, round and sticky bits, with round-to-nearest-even.
- Subnormal inputs and results are flushed to +0.
- An exact cancellation gives +0.
- A NaN operand, or (+Inf)+(-Inf), gives 0x7FC00000.
- Inf plus a finite value gives that Inf.
- Exponent overflow gives a signed Inf.
REQ-021 SHALL stick at 0x7FC00000 once the sum is NaN, until the batch is emitted.
REQ-022 SHALL ignore in_valid outside ACCEPT; upstream holds its data.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force:
- FSM to ACCEPT;
- sum, count, overflow and the latched operand to 0;
- out_valid and in_ready low while reset_n is asserted.
REQ-024 SHALL discard any partially accumulated batch, or an un-taken EMIT batch, on reset.
- The first batch after reset_n deasserts starts from zero.

Structure
REQ-025 SHALL take from the shared float package:
- the NaN constant 0x7FC00000;
- the float field widths and the bias (127);
- the FSM state enumeration.
REQ-026 SHALL contain one combinational sub-module, ieee754_adder (A, B -> result), instantiated once.
- The FSM, counter and int-to-float conversion stay in ieee754_accumulator.

Verification
REQ-027 SHALL cover: inputs 0x3F800000, 0x40000000, 0x40400000 (last) -> out_sum 0x40C00000, out_count 0x40400000, out_overflow 0.
REQ-028 SHALL cover: a single element 0x41000000 with last -> out_sum 0x41000000, out_count 0x3F800000, out_valid exactly 3 cycles after the handshake edge.
REQ-029 SHALL cover: 0x3F800000, then 0xBF800000 (last) -> out_sum 0x00000000; 0x7FC00001 in any batch -> out_sum 0x7FC00000.
REQ-030 SHALL cover: out_ready held low for 5 cycles in EMIT -> outputs unchanged and in_ready low throughout; on out_ready high the next batch starts from sum 0.
REQ-031 SHALL cover: COUNT_W=2 with 5 elements of 0x3F800000 -> out_count 0x40400000, out_overflow 1, out_sum 0x40A00000.
REQ-032 SHALL cover: reset_n pulsed low after 2 of 3 elements -> outputs go low immediately; a following batch 0x40000000 (last) -> out_sum 0x40000000, out_count 0x3F800000.
